panda_mem_arbiter: RTL
======================

Name: panda_mem_arbiter

Overview:
Shares one single-port panda_ram between two requesters: port 0 (instruction fetch) and port 1 (data load/store). The block enables unified instruction/data memory for multi-cycle or pipelined Panda cores.
- Per-port req/gnt/rvalid handshake with round-robin arbitration under contention.
- Routes the 1-cycle read response back to the owning port.
- Flags accesses outside the memory range.

Parameters:
AddrWidth, 10, memory word-address width; the RAM holds 2**AddrWidth 32-bit words.
BaseAddr, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
req_i  input  2  per-port request; index 0 = instr, 1 = data
addr_i  input  2x32  per-port byte address; bits [1:0] ignored
we_i  input  2x4  per-port byte write enables; 0 = read
wdata_i  input  2x32  per-port write data
gnt_o  output  2  per-port grant; combinational, same cycle as req
rvalid_o  output  2  per-port response valid, one cycle after the granted access
rdata_o  output  32  response read data, shared by both ports and qualified by rvalid_o
err_o  output  1  response error (out of range), qualified by rvalid_o
mem_ce_o  output  1  RAM chip enable
mem_we_o  output  4  RAM byte write enables
mem_addr_o  output  AddrWidth  RAM word address
mem_wdata_o  output  32  RAM write data
mem_rdata_i  input  32  RAM read data; valid one cycle after ce (no output register)

Behaviour:
- Reset values: rvalid_o=0, err_o=0, last-grant pointer=1 (so port 0 wins the first conflict), counters=0. Memory-side outputs are combinational; with req_i=0 they are ce=0, we=0.
- At most one grant per cycle; an access is accepted when req_i[n] && gnt_o[n].
- Single request: granted immediately.
- Both requesting: grant the port not granted most recently. The pointer updates on every accepted access, including uncontended ones.
- Requesters hold req/addr/we/wdata stable until granted; the arbiter keeps no request buffer.
- Range check: offset = addr - BaseAddr.
  - In range: offset < 4*2**AddrWidth.
  - In range: mem_ce_o=1, mem_we_o=we, mem_addr_o=offset[AddrWidth+1:2], mem_wdata_o=wdata.
  - Out of range: granted but mem_ce_o=0 and mem_we_o=0.
- Response: registered owner index, valid flag and error flag.
  - Next cycle, rvalid_o[owner]=1 for every accepted read and write.
  - rdata_o = mem_rdata_i for an in-range read, else 0.
  - err_o=1 for an out-of-range access.
- Throughput: one access per cycle total. Back-to-back accesses overlap, so the response of access N coincides with the grant of access N+1.
- Writes use the RAM's read-first behaviour; rdata on a write response is don't-care but must not be X after reset.
- Async reset mid-transaction: a pending response is dropped (rvalid_o=0) and the pointer resets. Requesters must re-issue.
- Simultaneous same-address accesses are serialized by grant order; a data write then instr read returns the new data.

Optional Feature:
Macro PANDA_MEM_ARB_PERF_EN.
- With it, adds output ports:
  - conflict_cnt_o (32): cycles with req_i=2'b11.
  - err_cnt_o (16): out-of-range accesses.
- Both counters saturate, never wrap, and reset to 0.
- Without it: ports and counters are absent and arbitration is identical.

Decomposition:
- Package panda_mem_arb_pkg:
  - typedef port_idx_e (PORT_INSTR=0, PORT_DATA=1).
  - struct mem_req_t {addr, we, wdata}.
  - constant NumPorts=2.
- Sub-module panda_rr_arbiter: 2-way round-robin grant logic plus last-grant pointer register.
- Top: range check, muxing, response registers.

Test Plan:
- Reset, then port 0 reads 0x08 with mem word 2 = 32'hDEADBEEF -> gnt_o=01 same cycle; next cycle rvalid_o=01, rdata_o=32'hDEADBEEF, err_o=0.
- Both ports hold req for 4 cycles (reads of 0x00 and 0x04) -> grants alternate 01,10,01,10; each rvalid goes to the matching port one cycle later.
- Port 1 writes 0x10, we=4'b0011, wdata=32'h1234_5678 over 32'hFFFF_FFFF, then port 0 reads 0x10 -> rdata_o=32'hFFFF_5678.
- AddrWidth=5, port 1 reads 0x80 -> gnt=10, mem_ce_o=0; next cycle rvalid_o=10, err_o=1, rdata_o=0.
- rst_ni pulled low in the cycle after a grant -> rvalid_o stays 0; after release, port 0 wins the first conflict.
- With PANDA_MEM_ARB_PERF_EN: 5 cycles of req_i=11 plus 2 out-of-range accesses -> conflict_cnt_o=5, err_cnt_o=2.

Source files
------------

// File: rtl/panda_mem_arb_pkg.sv
// Shared types for the two-port Panda memory arbiter.
package panda_mem_arb_pkg;

  localparam int NumPorts = 2;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_idx_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/panda_rr_arbiter.sv
// Two-way round-robin grant with a last-grant pointer.
// Grant is combinational; the pointer moves on every accepted access.
module panda_rr_arbiter
  import panda_mem_arb_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] req_i,
  output logic [NumPorts-1:0] gnt_o,
  output port_idx_e           idx_o
);

  port_idx_e last_q, last_d;

  // Single requester wins outright; on conflict the port not granted last wins.
  always_comb begin
    gnt_o = '0;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == PORT_DATA) ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
    idx_o  = gnt_o[1] ? PORT_DATA : PORT_INSTR;
    last_d = (|gnt_o) ? idx_o : last_q;
  end

  // Pointer resets to the data port so the instruction port wins the first conflict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= PORT_DATA;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/panda_mem_arbiter.sv
// Shares one single-port RAM between instruction fetch (port 0) and data
// (port 1). Range-checks each access, drives the RAM combinationally and
// routes the 1-cycle read response back to its owner.
// Optional perf counters: define PANDA_MEM_ARB_PERF_EN.
module panda_mem_arbiter
  import panda_mem_arb_pkg::*;
#(
  parameter int unsigned AddrWidth = 10,
  parameter logic [31:0] BaseAddr  = 32'h0000_0000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumPorts-1:0]           req_i,
  input  logic [NumPorts-1:0][31:0]     addr_i,
  input  logic [NumPorts-1:0][3:0]      we_i,
  input  logic [NumPorts-1:0][31:0]     wdata_i,
  output logic [NumPorts-1:0]           gnt_o,
  output logic [NumPorts-1:0]           rvalid_o,
  output logic [31:0]                   rdata_o,
  output logic                          err_o,
  output logic                          mem_ce_o,
  output logic [3:0]                    mem_we_o,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  input  logic [31:0]                   mem_rdata_i
`ifdef PANDA_MEM_ARB_PERF_EN
  ,
  output logic [31:0]                   conflict_cnt_o,
  output logic [15:0]                   err_cnt_o
`endif
);

  // Byte size of the RAM; one extra bit so AddrWidth up to 30 still fits.
  localparam logic [32:0] MemBytes = 33'd4 << AddrWidth;

  mem_req_t [NumPorts-1:0] port_req;
  mem_req_t                sel_req;
  port_idx_e               gnt_idx;
  logic [31:0]             offset;
  logic                    accept;
  logic                    in_range;

  logic [NumPorts-1:0]     rvalid_q;
  logic                    err_q;
  logic                    rd_q;

  panda_rr_arbiter u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .gnt_o  (gnt_o),
    .idx_o  (gnt_idx)
  );

  // Bundle per-port fields, select the granted one and range-check it.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      port_req[p].addr  = addr_i[p];
      port_req[p].we    = we_i[p];
      port_req[p].wdata = wdata_i[p];
    end
    sel_req  = port_req[gnt_idx];
    accept   = |gnt_o;
    offset   = sel_req.addr - BaseAddr;
    in_range = ({1'b0, offset} < MemBytes);
  end

  // RAM side: out-of-range accesses are granted but never touch the RAM.
  always_comb begin
    mem_ce_o    = accept & in_range;
    mem_we_o    = mem_ce_o ? sel_req.we : 4'b0000;
    mem_addr_o  = offset[AddrWidth+1:2];
    mem_wdata_o = sel_req.wdata;
  end

  // Response bookkeeping: owner, error and whether RAM data is meaningful.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      rvalid_q <= gnt_o;
      err_q    <= accept & ~in_range;
      rd_q     <= accept & in_range & (sel_req.we == 4'b0000);
    end
  end

  // Write and error responses return zero so rdata is never X after reset.
  always_comb begin
    rvalid_o = rvalid_q;
    err_o    = err_q;
    rdata_o  = rd_q ? mem_rdata_i : 32'h0;
  end

`ifdef PANDA_MEM_ARB_PERF_EN
  logic [31:0] conflict_cnt_q;
  logic [15:0] err_cnt_q;

  // Saturating counters for contention cycles and out-of-range accesses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
      err_cnt_q      <= '0;
    end else begin
      if ((&req_i) && (conflict_cnt_q != '1)) conflict_cnt_q <= conflict_cnt_q + 32'd1;
      if (accept && !in_range && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
  assign err_cnt_o      = err_cnt_q;
`endif

endmodule
